// File: rtl/valu_pkg.sv
// valu_pkg
//   Types shared by the vector ALU sequencer and its ALU: opcode encoding,
//   sequencer state encoding, the per-vector flag bundle and the signed
//   overflow helper used by add/sub.
package valu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_RSVD = 2'd3
  } valu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } valu_state_e;

  // Cycles spent draining the read->ALU->write pipe after the last read.
  localparam int unsigned DRAIN_CYCLES = 2;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic negative;
  } valu_flags_t;

  // Two's-complement add overflow: operands agree in sign, result does not.
  // For a-b pass the inverted sign of b.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu.sv
// alu
//   Registered element ALU. Computes add / sub / mul (low half) on a_i, b_i
//   and captures result plus signed overflow when en_i is high.
// Ports
//   clk_i, reset_i      clock, asynchronous active-high reset
//   en_i                capture enable (operands valid this cycle)
//   op_i                opcode: 0 add, 1 sub (a-b), 2 mul, 3 add
//   a_i, b_i            operands
//   result_o            registered result
//   overflow_o          registered signed overflow of result_o
module alu
  import valu_pkg::*;
#(
  parameter int vdw_p    = 32,
  parameter int op_len_p = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [op_len_p-1:0] op_i,
  input  logic [vdw_p-1:0]    a_i,
  input  logic [vdw_p-1:0]    b_i,
  output logic [vdw_p-1:0]    result_o,
  output logic                overflow_o
);

  localparam logic [op_len_p-1:0] OPC_SUB = op_len_p'(OP_SUB);
  localparam logic [op_len_p-1:0] OPC_MUL = op_len_p'(OP_MUL);

  logic [vdw_p-1:0]   sum;
  logic [vdw_p-1:0]   diff;
  logic [2*vdw_p-1:0] a_ext;
  logic [2*vdw_p-1:0] b_ext;
  logic [2*vdw_p-1:0] prod;
  logic [vdw_p:0]     prod_hi;
  logic [vdw_p-1:0]   res;
  logic               ovf;

  always_comb begin
    sum   = a_i + b_i;
    diff  = a_i - b_i;
    // Sign-extend so the low 2*vdw_p bits of the product are the exact
    // signed product.
    a_ext = {{vdw_p{a_i[vdw_p-1]}}, a_i};
    b_ext = {{vdw_p{b_i[vdw_p-1]}}, b_i};
    prod  = a_ext * b_ext;
    // Product fits in vdw_p signed bits only if the upper half plus the
    // result sign bit are all copies of one value.
    prod_hi = prod[2*vdw_p-1:vdw_p-1];
    res = sum;
    ovf = add_overflow(a_i[vdw_p-1], b_i[vdw_p-1], sum[vdw_p-1]);
    if (op_i == OPC_SUB) begin
      res = diff;
      ovf = add_overflow(a_i[vdw_p-1], ~b_i[vdw_p-1], diff[vdw_p-1]);
    end else if (op_i == OPC_MUL) begin
      res = prod[vdw_p-1:0];
      ovf = !((&prod_hi) || (~|prod_hi));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      result_o   <= '0;
      overflow_o <= 1'b0;
    end else if (en_i) begin
      result_o   <= res;
      overflow_o <= ovf;
    end
  end

endmodule

// File: rtl/valu_seq.sv
// valu_seq
//   Vector ALU sequencer. Accepts one command at a time, streams element
//   reads from two source registers, runs each element pair through the
//   ALU and writes results to the destination register two cycles after the
//   corresponding read. Per-vector flags accumulate over written elements.
// Ports
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   cmd_v_i / cmd_ready_o     command handshake (ready only when idle)
//   cmd_op_i, cmd_len_i       opcode, element count 0..vlen_p
//   cmd_vd_i/vs1_i/vs2_i      destination / source register indices
//   rd_v_o, rd_reg_a/b_o,
//   rd_el_o, rd_a_i, rd_b_i   register-file read port, data one cycle later
//   wr_v_o, wr_reg_o,
//   wr_el_o, wr_data_o        register-file write port
//   done_o                    one-cycle completion pulse
//   flag_*_o                  vector flags, held until the next accept
//
// state | meaning
// IDLE  | ready for a command
// RUN   | issuing one element read per cycle
// DRAIN | last reads flowing through ALU and write stage
// DONE  | completion pulse, flags valid
module valu_seq
  import valu_pkg::*;
#(
  parameter int vdw_p    = 32,
  parameter int op_len_p = 2,
  parameter int vlen_p   = 16,
  parameter int vregs_p  = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         cmd_v_i,
  output logic                         cmd_ready_o,
  input  logic [op_len_p-1:0]          cmd_op_i,
  input  logic [$clog2(vlen_p+1)-1:0]  cmd_len_i,
  input  logic [$clog2(vregs_p)-1:0]   cmd_vd_i,
  input  logic [$clog2(vregs_p)-1:0]   cmd_vs1_i,
  input  logic [$clog2(vregs_p)-1:0]   cmd_vs2_i,
  output logic                         rd_v_o,
  output logic [$clog2(vregs_p)-1:0]   rd_reg_a_o,
  output logic [$clog2(vregs_p)-1:0]   rd_reg_b_o,
  output logic [$clog2(vlen_p)-1:0]    rd_el_o,
  input  logic [vdw_p-1:0]             rd_a_i,
  input  logic [vdw_p-1:0]             rd_b_i,
  output logic                         wr_v_o,
  output logic [$clog2(vregs_p)-1:0]   wr_reg_o,
  output logic [$clog2(vlen_p)-1:0]    wr_el_o,
  output logic [vdw_p-1:0]             wr_data_o,
  output logic                         done_o,
  output logic                         flag_overflow_o,
  output logic                         flag_zero_o,
  output logic                         flag_negative_o
);

  localparam int LW = $clog2(vlen_p+1);
  localparam int EW = $clog2(vlen_p);
  localparam int RW = $clog2(vregs_p);
  localparam int DW = $clog2(DRAIN_CYCLES);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]          state_q;
  logic [op_len_p-1:0] op_q;
  logic [LW-1:0]       len_q;
  logic [RW-1:0]       vd_q;
  logic [RW-1:0]       vs1_q;
  logic [RW-1:0]       vs2_q;
  logic [EW-1:0]       el_cnt_q;
  logic [DW-1:0]       drain_cnt_q;

  // Element index and valid ride alongside the data: stage 1 = ALU input,
  // stage 2 = ALU output / write.
  logic                v_s1_q;
  logic                v_s2_q;
  logic [EW-1:0]       el_s1_q;
  logic [EW-1:0]       el_s2_q;

  valu_flags_t         flags_q;
  logic [vdw_p-1:0]    alu_res;
  logic                alu_ovf;
  logic                accept;
  logic                last_el;

  assign cmd_ready_o = (state_q == S_IDLE);
  assign accept      = cmd_v_i & cmd_ready_o;
  assign last_el     = ((LW'(el_cnt_q) + LW'(1)) == len_q);

  assign rd_v_o      = (state_q == S_RUN);
  assign rd_reg_a_o  = vs1_q;
  assign rd_reg_b_o  = vs2_q;
  assign rd_el_o     = el_cnt_q;

  assign wr_v_o      = v_s2_q;
  assign wr_reg_o    = vd_q;
  assign wr_el_o     = el_s2_q;
  assign wr_data_o   = alu_res;

  assign done_o          = (state_q == S_DONE);
  assign flag_overflow_o = flags_q.overflow;
  assign flag_zero_o     = flags_q.zero;
  assign flag_negative_o = flags_q.negative;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      el_cnt_q    <= '0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            el_cnt_q <= '0;
            state_q  <= (cmd_len_i == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (last_el) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= DW'(DRAIN_CYCLES - 1);
          end else begin
            el_cnt_q <= el_cnt_q + EW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q <= S_DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q - DW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      op_q  <= '0;
      len_q <= '0;
      vd_q  <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
    end else if (accept) begin
      op_q  <= cmd_op_i;
      len_q <= cmd_len_i;
      vd_q  <= cmd_vd_i;
      vs1_q <= cmd_vs1_i;
      vs2_q <= cmd_vs2_i;
    end
  end

  // Clearing the valids on reset is what guarantees no write escapes for
  // reads that were already issued.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_s1_q  <= 1'b0;
      v_s2_q  <= 1'b0;
      el_s1_q <= '0;
      el_s2_q <= '0;
    end else begin
      v_s1_q  <= rd_v_o;
      el_s1_q <= rd_el_o;
      v_s2_q  <= v_s1_q;
      el_s2_q <= el_s1_q;
    end
  end

  // Accept presets the identity values so len=0 reports zero=1 directly.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      flags_q <= '0;
    end else if (accept) begin
      flags_q.overflow <= 1'b0;
      flags_q.zero     <= 1'b1;
      flags_q.negative <= 1'b0;
    end else if (v_s2_q) begin
      flags_q.overflow <= flags_q.overflow | alu_ovf;
      flags_q.zero     <= flags_q.zero & (alu_res == '0);
      flags_q.negative <= flags_q.negative | alu_res[vdw_p-1];
    end
  end

  alu #(
    .vdw_p    (vdw_p),
    .op_len_p (op_len_p)
  ) u_alu (
    .clk_i      (clk_i),
    .reset_i    (~reset_n_i),
    .en_i       (v_s1_q),
    .op_i       (op_q),
    .a_i        (rd_a_i),
    .b_i        (rd_b_i),
    .result_o   (alu_res),
    .overflow_o (alu_ovf)
  );

endmodule

// File: tb/tb_valu_seq.sv
// tb_valu_seq
//   Directed bench for valu_seq: a register-file model answers reads one
//   cycle after rd_v_o, a monitor logs reads, writes, done pulses and
//   accepts with cycle stamps, and each test task checks the log against
//   hand-computed expectations.
module tb_valu_seq;

  localparam int VREGS = 8;
  localparam int VLEN  = 16;
  localparam int LOGN  = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_v;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_len;
  logic [2:0]  cmd_vd, cmd_vs1, cmd_vs2;
  logic        rd_v;
  logic [2:0]  rd_reg_a, rd_reg_b;
  logic [3:0]  rd_el;
  logic [31:0] rd_a, rd_b;
  logic        wr_v;
  logic [2:0]  wr_reg;
  logic [3:0]  wr_el;
  logic [31:0] wr_data;
  logic        done;
  logic        f_ovf, f_zero, f_neg;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] vrf [VREGS][VLEN];

  int          rd_n = 0, wr_n = 0, dn_n = 0, acc_n = 0;
  int          rd_cyc [LOGN];
  logic [3:0]  rd_el_l [LOGN];
  logic [2:0]  rd_ra_l [LOGN];
  logic [2:0]  rd_rb_l [LOGN];
  int          wr_cyc [LOGN];
  logic [3:0]  wr_el_l [LOGN];
  logic [2:0]  wr_reg_l [LOGN];
  logic [31:0] wr_dat_l [LOGN];
  int          dn_cyc [LOGN];
  logic [2:0]  dn_flags [LOGN];
  int          acc_cyc_l [LOGN];

  valu_seq #(
    .vdw_p(32), .op_len_p(2), .vlen_p(VLEN), .vregs_p(VREGS)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .cmd_v_i         (cmd_v),
    .cmd_ready_o     (cmd_ready),
    .cmd_op_i        (cmd_op),
    .cmd_len_i       (cmd_len),
    .cmd_vd_i        (cmd_vd),
    .cmd_vs1_i       (cmd_vs1),
    .cmd_vs2_i       (cmd_vs2),
    .rd_v_o          (rd_v),
    .rd_reg_a_o      (rd_reg_a),
    .rd_reg_b_o      (rd_reg_b),
    .rd_el_o         (rd_el),
    .rd_a_i          (rd_a),
    .rd_b_i          (rd_b),
    .wr_v_o          (wr_v),
    .wr_reg_o        (wr_reg),
    .wr_el_o         (wr_el),
    .wr_data_o       (wr_data),
    .done_o          (done),
    .flag_overflow_o (f_ovf),
    .flag_zero_o     (f_zero),
    .flag_negative_o (f_neg)
  );

  always #5 clk = ~clk;

  // cyc = index of the clock period that follows the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file read model: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_v) begin
      rd_a <= vrf[rd_reg_a][rd_el];
      rd_b <= vrf[rd_reg_b][rd_el];
    end
  end

  // Accept log stamped with the period that follows the accepting edge.
  always @(posedge clk) begin
    if (reset_n && cmd_v && cmd_ready && acc_n < LOGN) begin
      acc_cyc_l[acc_n] = cyc + 1;
      acc_n++;
    end
  end

  always @(negedge clk) begin
    if (rd_v && rd_n < LOGN) begin
      rd_cyc[rd_n] = cyc; rd_el_l[rd_n] = rd_el;
      rd_ra_l[rd_n] = rd_reg_a; rd_rb_l[rd_n] = rd_reg_b;
      rd_n++;
    end
    if (wr_v && wr_n < LOGN) begin
      wr_cyc[wr_n] = cyc; wr_el_l[wr_n] = wr_el;
      wr_reg_l[wr_n] = wr_reg; wr_dat_l[wr_n] = wr_data;
      wr_n++;
    end
    if (done && dn_n < LOGN) begin
      dn_cyc[dn_n] = cyc; dn_flags[dn_n] = {f_ovf, f_zero, f_neg};
      dn_n++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int len, input int vd,
                       input int vs1, input int vs2, input bit hold,
                       input bit rel, output int acc);
    tick();
    cmd_v = 1'b1; cmd_op = op; cmd_len = 5'(len);
    cmd_vd = 3'(vd); cmd_vs1 = 3'(vs1); cmd_vs2 = 3'(vs2);
    if (rel) reset_n = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) cmd_v = 1'b0;
  endtask

  task automatic wait_done(input int db, input int budget, input string name);
    int n;
    n = 0;
    while (dn_n == db && n < budget) begin
      tick();
      n++;
    end
    if (dn_n == db) begin
      vectors++; miscompares++;
      $display("FAIL %s done_timeout: no done_o within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({cmd_ready, rd_v, wr_v, done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_outputs: ready/rd_v/wr_v/done=%b want 1000",
               {cmd_ready, rd_v, wr_v, done});
    end
    vectors++;
    if ({f_ovf, f_zero, f_neg} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000", {f_ovf, f_zero, f_neg});
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if (cmd_ready !== 1'b1 || rd_v !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b rd_v=%b want 1 0", cmd_ready, rd_v);
    end
  endtask

  task automatic test_add();
    int acc, rb, wb, db;
    logic [31:0] exp [4];
    exp = '{32'd2, 32'd3, 32'd4, 32'd5};
    for (int i = 0; i < 4; i++) begin
      vrf[1][i] = 32'(i + 1);
      vrf[2][i] = 32'd1;
    end
    rb = rd_n; wb = wr_n; db = dn_n;
    issue(2'd0, 4, 3, 1, 2, 1'b0, 1'b0, acc);
    wait_done(db, 40, "add");
    tick();
    vectors++;
    if (rd_n - rb !== 4 || wr_n - wb !== 4) begin
      miscompares++;
      $display("FAIL add_counts: reads %0d writes %0d want 4 4", rd_n - rb, wr_n - wb);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (rd_cyc[rb+i] !== acc + i || rd_el_l[rb+i] !== 4'(i) ||
          rd_ra_l[rb+i] !== 3'd1 || rd_rb_l[rb+i] !== 3'd2) begin
        miscompares++;
        $display("FAIL add_rd[%0d]: cyc %0d el %0d a %0d b %0d want cyc %0d el %0d a 1 b 2",
                 i, rd_cyc[rb+i], rd_el_l[rb+i], rd_ra_l[rb+i], rd_rb_l[rb+i], acc + i, i);
      end
      vectors++;
      if (wr_cyc[wb+i] !== acc + i + 2 || wr_el_l[wb+i] !== 4'(i) ||
          wr_reg_l[wb+i] !== 3'd3 || wr_dat_l[wb+i] !== exp[i]) begin
        miscompares++;
        $display("FAIL add_wr[%0d]: cyc %0d el %0d reg %0d data %0h want cyc %0d el %0d reg 3 data %0h",
                 i, wr_cyc[wb+i], wr_el_l[wb+i], wr_reg_l[wb+i], wr_dat_l[wb+i], acc + i + 2, i, exp[i]);
      end
    end
    vectors++;
    if (dn_cyc[db] !== acc + 6 || dn_flags[db] !== 3'b000) begin
      miscompares++;
      $display("FAIL add_done: cyc %0d flags %b want cyc %0d flags 000",
               dn_cyc[db], dn_flags[db], acc + 6);
    end
  endtask

  task automatic test_sub();
    int acc, wb, db;
    logic [31:0] exp [2];
    exp = '{32'd2, 32'hFFFF_FFFA};
    vrf[4][0] = 32'd10; vrf[4][1] = 32'd4;
    vrf[5][0] = 32'd8;  vrf[5][1] = 32'd10;
    wb = wr_n; db = dn_n;
    issue(2'd1, 2, 6, 4, 5, 1'b0, 1'b0, acc);
    wait_done(db, 40, "sub");
    vectors++;
    if (wr_n - wb !== 2) begin
      miscompares++;
      $display("FAIL sub_count: writes %0d want 2", wr_n - wb);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (wr_dat_l[wb+i] !== exp[i] || wr_cyc[wb+i] !== acc + i + 2 || wr_reg_l[wb+i] !== 3'd6) begin
        miscompares++;
        $display("FAIL sub_wr[%0d]: data %0h cyc %0d reg %0d want %0h cyc %0d reg 6",
                 i, wr_dat_l[wb+i], wr_cyc[wb+i], wr_reg_l[wb+i], exp[i], acc + i + 2);
      end
    end
    vectors++;
    if (dn_cyc[db] !== acc + 4 || dn_flags[db] !== 3'b001) begin
      miscompares++;
      $display("FAIL sub_done: cyc %0d flags %b want cyc %0d flags 001",
               dn_cyc[db], dn_flags[db], acc + 4);
    end
  endtask

  task automatic test_mul_and_overflow();
    int acc, wb, db;
    vrf[0][0] = 32'd11; vrf[7][0] = 32'd4;
    wb = wr_n; db = dn_n;
    issue(2'd2, 1, 5, 0, 7, 1'b0, 1'b0, acc);
    wait_done(db, 40, "mul");
    vectors++;
    if (wr_n - wb !== 1 || wr_dat_l[wb] !== 32'd44 || wr_cyc[wb] !== acc + 2 ||
        dn_cyc[db] !== acc + 3 || dn_flags[db] !== 3'b000) begin
      miscompares++;
      $display("FAIL mul: writes %0d data %0d wcyc %0d dcyc %0d flags %b want 1 44 %0d %0d 000",
               wr_n - wb, wr_dat_l[wb], wr_cyc[wb], dn_cyc[db], dn_flags[db], acc + 2, acc + 3);
    end
    vrf[1][0] = 32'h7FFF_FFFF; vrf[2][0] = 32'd1;
    wb = wr_n; db = dn_n;
    issue(2'd0, 1, 4, 1, 2, 1'b0, 1'b0, acc);
    wait_done(db, 40, "ovf");
    vectors++;
    if (wr_n - wb !== 1 || wr_dat_l[wb] !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL ovf_data: writes %0d data %0h want 1 80000000", wr_n - wb, wr_dat_l[wb]);
    end
    vectors++;
    if (dn_flags[db] !== 3'b101) begin
      miscompares++;
      $display("FAIL ovf_flags: got %b want 101", dn_flags[db]);
    end
  endtask

  task automatic test_len0();
    int acc, rb, wb, db;
    rb = rd_n; wb = wr_n; db = dn_n;
    issue(2'd0, 0, 1, 2, 3, 1'b0, 1'b0, acc);
    wait_done(db, 10, "len0");
    repeat (4) tick();
    vectors++;
    if (dn_cyc[db] !== acc || dn_flags[db] !== 3'b010) begin
      miscompares++;
      $display("FAIL len0_done: cyc %0d flags %b want cyc %0d flags 010",
               dn_cyc[db], dn_flags[db], acc);
    end
    vectors++;
    if (rd_n !== rb || wr_n !== wb || dn_n - db !== 1) begin
      miscompares++;
      $display("FAIL len0_traffic: reads %0d writes %0d dones %0d want 0 0 1",
               rd_n - rb, wr_n - wb, dn_n - db);
    end
    vectors++;
    if ({f_ovf, f_zero, f_neg} !== 3'b010) begin
      miscompares++;
      $display("FAIL len0_hold: flags %b want 010", {f_ovf, f_zero, f_neg});
    end
  endtask

  task automatic test_zero_inplace();
    int acc, wb, db;
    vrf[1][0] = 32'h7FFF_FFFF; vrf[1][1] = 32'd3; vrf[1][2] = 32'hFFFF_0000;
    wb = wr_n; db = dn_n;
    issue(2'd1, 3, 1, 1, 1, 1'b0, 1'b0, acc);
    wait_done(db, 40, "zero");
    vectors++;
    if (wr_n - wb !== 3 || wr_dat_l[wb] !== 32'd0 || wr_dat_l[wb+1] !== 32'd0 ||
        wr_dat_l[wb+2] !== 32'd0 || wr_reg_l[wb+2] !== 3'd1 || wr_el_l[wb+2] !== 4'd2) begin
      miscompares++;
      $display("FAIL zero_wr: writes %0d data %0h %0h %0h reg %0d el %0d want 3 0 0 0 reg 1 el 2",
               wr_n - wb, wr_dat_l[wb], wr_dat_l[wb+1], wr_dat_l[wb+2], wr_reg_l[wb+2], wr_el_l[wb+2]);
    end
    vectors++;
    if (dn_flags[db] !== 3'b010) begin
      miscompares++;
      $display("FAIL zero_flags: got %b want 010", dn_flags[db]);
    end
  endtask

  task automatic test_reset_mid();
    int acc, rb, wb, db, wsnap, dsnap, n;
    for (int i = 0; i < 8; i++) begin
      vrf[3][i] = 32'(100 + i);
      vrf[6][i] = 32'd1;
    end
    rb = rd_n; wb = wr_n; db = dn_n;
    issue(2'd0, 8, 2, 3, 6, 1'b0, 1'b0, acc);
    n = 0;
    while (rd_n - rb < 3 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (rd_n - rb !== 3) begin
      miscompares++;
      $display("FAIL rst_mid_reads: got %0d reads want 3", rd_n - rb);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    wsnap = wr_n; dsnap = dn_n;
    #1;
    vectors++;
    if ({rd_v, wr_v, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid_async: rd_v/wr_v/done=%b want 000", {rd_v, wr_v, done});
    end
    repeat (3) tick();
    vectors++;
    if (wsnap - wb !== 1 || wr_n !== wsnap || dn_n !== dsnap || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_abort: pre-writes %0d post-writes %0d dones %0d ready %b want 1 0 0 1",
               wsnap - wb, wr_n - wsnap, dn_n - dsnap, cmd_ready);
    end
    issue(2'd0, 2, 2, 3, 6, 1'b0, 1'b1, acc);
    wait_done(dsnap, 40, "rst_mid_next");
    vectors++;
    if (wr_n - wsnap !== 2 || wr_dat_l[wsnap] !== 32'd101 || wr_dat_l[wsnap+1] !== 32'd102 ||
        wr_cyc[wsnap] !== acc + 2 || wr_el_l[wsnap+1] !== 4'd1) begin
      miscompares++;
      $display("FAIL rst_mid_next_wr: writes %0d data %0d %0d cyc %0d el1 %0d want 2 101 102 %0d 1",
               wr_n - wsnap, wr_dat_l[wsnap], wr_dat_l[wsnap+1], wr_cyc[wsnap], wr_el_l[wsnap+1], acc + 2);
    end
    vectors++;
    if (dn_n - dsnap !== 1 || dn_cyc[dsnap] !== acc + 4 || dn_flags[dsnap] !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_mid_next_done: dones %0d cyc %0d flags %b want 1 %0d 000",
               dn_n - dsnap, dn_cyc[dsnap], dn_flags[dsnap], acc + 4);
    end
  endtask

  task automatic test_back_to_back();
    int acc, wb, db, ab;
    logic [31:0] exp [4];
    exp = '{32'd18, 32'd14, 32'd18, 32'd14};
    vrf[4][0] = 32'd10; vrf[4][1] = 32'd4;
    vrf[5][0] = 32'd8;  vrf[5][1] = 32'd10;
    wb = wr_n; db = dn_n; ab = acc_n;
    issue(2'd0, 2, 5, 4, 5, 1'b1, 1'b0, acc);
    tick();
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_busy_ready: got %b want 0", cmd_ready);
    end
    wait_done(db, 40, "b2b_first");
    tick();
    @(posedge clk);
    #1;
    cmd_v = 1'b0;
    wait_done(db + 1, 40, "b2b_second");
    vectors++;
    if (acc_n - ab !== 2 || acc_cyc_l[ab] !== acc || acc_cyc_l[ab+1] !== dn_cyc[db] + 2) begin
      miscompares++;
      $display("FAIL b2b_accepts: count %0d first %0d second %0d want 2 %0d %0d",
               acc_n - ab, acc_cyc_l[ab], acc_cyc_l[ab+1], acc, dn_cyc[db] + 2);
    end
    vectors++;
    if (wr_n - wb !== 4) begin
      miscompares++;
      $display("FAIL b2b_count: writes %0d want 4", wr_n - wb);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wr_dat_l[wb+i] !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b_wr[%0d]: data %0d want %0d", i, wr_dat_l[wb+i], exp[i]);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cmd_v = 1'b0; cmd_op = '0; cmd_len = '0;
    cmd_vd = '0; cmd_vs1 = '0; cmd_vs2 = '0;
    for (int r = 0; r < VREGS; r++)
      for (int e = 0; e < VLEN; e++)
        vrf[r][e] = '0;
    test_reset();
    test_add();
    test_sub();
    test_mul_and_overflow();
    test_len0();
    test_zero_inplace();
    test_reset_mid();
    test_back_to_back();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
